// File: rtl/shift_pkg.sv
// Shared shift op-codes and sequencer state encoding, also used by the instruction controller.
package shift_pkg;

  localparam int unsigned SHIFT_W = 16;

  typedef enum logic [1:0] {
    OP_NONE   = 2'b00,
    OP_LEFT   = 2'b01,
    OP_RIGHT  = 2'b10,
    OP_SIGNED = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } seq_state_t;

endpackage

// File: rtl/shifter.sv
// Single-step 16-bit shifter: one-bit left, logical right or arithmetic right per op.
module shifter
  import shift_pkg::*;
(
  input  logic [SHIFT_W-1:0] in,
  input  logic [1:0]         shift,
  output logic [SHIFT_W-1:0] sout
);

  always_comb begin
    sout = in;
    case (shift_op_t'(shift))
      OP_LEFT:   sout = {in[SHIFT_W-2:0], 1'b0};
      OP_RIGHT:  sout = {1'b0, in[SHIFT_W-1:1]};
      OP_SIGNED: sout = {in[SHIFT_W-1], in[SHIFT_W-1:1]};
      default:   sout = in;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-bit shift controller iterating the single-step shifter once per clock.
// Optional SHIFT_SEQ_EARLY_EXIT_EN: leave RUN as soon as the shifter reaches a fixpoint.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned AMT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_op,
  input  logic [AMT_W-1:0]  in_amt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  seq_state_t        state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  shift_op_t         op_q, op_d;
  logic [AMT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] sout;
  logic              fixpoint;

  shifter u_shifter (
    .in    (data_q),
    .shift (op_q),
    .sout  (sout)
  );

`ifdef SHIFT_SEQ_EARLY_EXIT_EN
  assign fixpoint = (sout == data_q);
`else
  assign fixpoint = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      op_q      <= OP_NONE;
      cnt_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      in_ready  <= (state_d == ST_IDLE);
      out_valid <= (state_d == ST_DONE);
      busy      <= (state_d != ST_IDLE);
    end
  end

  // Next-state and working-register update
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d = in_data;
          op_d   = shift_op_t'(in_op);
          cnt_d  = in_amt;
          if (in_amt == AMT_W'(0) || shift_op_t'(in_op) == OP_NONE) state_d = ST_DONE;
          else                                                       state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (fixpoint) begin
          state_d = ST_DONE;
        end else begin
          data_d = sout;
          cnt_d  = cnt_q - AMT_W'(1);
          if (cnt_q == AMT_W'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign out_data = data_q;

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Multi-bit shift controller for the datapath's 16-bit single-step shifter. It accepts an operand, a shift op and a shift amount, then iterates the shifter once per clock, feeding the output back into a working register. It sits between the instruction controller and the datapath, turning "shift by N" requests into N sequenced single-bit shifts. Requests use a valid/ready handshake; the result is held until it is acknowledged.

Parameters:
DATA_W, 16, operand width; must be 16, to match the shifter instance.
AMT_W, 4, shift-amount width; maximum amount is 2**AMT_W-1 = 15.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous reset, active-low.
in_valid  input  1  request present.
in_ready  output  1  block can accept a request (IDLE only).
in_data  input  DATA_W  operand.
in_op  input  2  shift op: 00 NONE, 01 LEFT, 10 RIGHT (logical), 11 SIGNED (arithmetic right).
in_amt  input  AMT_W  number of single-bit shifts.
out_valid  output  1  result available (DONE only).
out_ready  input  1  consumer accepts the result.
out_data  output  DATA_W  result; the working register, driven straight from a flop.
busy  output  1  high in RUN or DONE.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state IDLE, out_data 0, out_valid 0, in_ready 1, busy 0; count and op registers are 0.
- Reset asserted mid-operation aborts the operation immediately; no partial result is ever presented.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at a clock edge: data_q<=in_data, op_q<=in_op, cnt_q<=in_amt.
  - If in_amt==0 or in_op==NONE, next state is DONE; otherwise next state is RUN.
- RUN:
  - Each cycle: data_q<=shifter(data_q, op_q), cnt_q<=cnt_q-1.
  - When cnt_q==1 at the edge, next state is DONE.
  - in_valid is ignored in RUN.
- DONE:
  - out_valid=1 and out_data=data_q, both held stable until out_ready.
  - On out_ready, next state is IDLE and out_valid drops next cycle.
  - A new request is not accepted in the same cycle as the result handshake; the earliest new accept is the following cycle.
- Latency: out_valid rises effective_amt+1 clock edges after the accept edge, where effective_amt=0 for NONE.
  - Examples: amt 0 gives 1 cycle, amt 15 gives 16 cycles.
- Width and arithmetic rules:
  - LEFT and RIGHT fill with 0; SIGNED replicates bit 15.
  - Amounts up to 15 are exact: no wrap, no saturation beyond the natural shift result.
- out_data in IDLE holds the last result; it is 0 only after reset.
- cnt_q never underflows: RUN exits at cnt_q==1, and cnt_q==0 never enters RUN.

Optional Feature:
Macro SHIFT_SEQ_EARLY_EXIT_EN.
- Defined: in RUN, if the shifter output equals data_q (fixpoint: 0x0000 for LEFT/RIGHT, 0x0000 or 0xFFFF for SIGNED), transition to DONE at that edge without decrementing.
  - Result value is unchanged; only latency shrinks.
- Undefined: latency is always effective_amt+1.

Decomposition:
- Package shift_pkg:
  - Op-code constants and typedef shift_op_t (NONE/LEFT/RIGHT/SIGNED, 2-bit).
  - State enum seq_state_t (IDLE/RUN/DONE).
  - Both shared with the instruction controller.
- One sub-module: the team's existing shifter (in, shift, sout), instantiated once combinationally on data_q/op_q. No other sub-modules.

Test Plan:
- Reset: drive rst_n=0 mid-RUN (LEFT, amt 10) → out_valid=0, out_data=0x0000, in_ready=1 immediately; after release, the next request completes normally.
- LEFT, in_data=0x0001, amt=4 → out_data=0x0010, out_valid 5 cycles after accept; RIGHT, 0x8000, amt=3 → 0x1000.
- SIGNED, 0x8000, amt=3 → 0xF000; SIGNED, 0x4000, amt=15 → 0x0000; LEFT, 0xFFFF, amt=15 → 0x8000.
- NONE, 0xBEEF, amt=7 and LEFT, 0xBEEF, amt=0 → out_data=0xBEEF after 1 cycle each.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 and new data → out_data and out_valid stable, in_ready=0, no new accept; release → IDLE next cycle, then the new request is accepted.
- With SHIFT_SEQ_EARLY_EXIT_EN: LEFT, 0x8000, amt=15 → 0x0000 with latency 3 cycles (16 without the macro); SIGNED, 0xFFFF, amt=15 → 0xFFFF with latency 2.
